// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment encoding table, decode result type and FSM state codes
package seg7_pkg;

  // Encoder table: bits[7:1] = segments A..G, bit0 = DP (always 0 here).
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg_decode_t;

endpackage

// File: rtl/seven_segment_to_binary_if.sv
// rtl/seven_segment_to_binary_if.sv - segment input bus and decoded result outputs
interface seven_segment_to_binary_if;
  logic [7:0] i_Segments;
  logic [3:0] o_Binary_Num;
  logic       o_DV;
  logic       o_Err;
  logic       o_Blank;
  logic       o_DP;

  modport master (
    output i_Segments,
    input  o_Binary_Num, o_DV, o_Err, o_Blank, o_DP
  );

  modport slave (
    input  i_Segments,
    output o_Binary_Num, o_DV, o_Err, o_Blank, o_DP
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational A..G pattern to {valid, blank, nibble}
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]  pattern_i,
  output seg_decode_t decode_o
);

  always_comb begin
    decode_o       = '0;
    decode_o.blank = (pattern_i == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG_CODES[i][7:1]) begin
        decode_o.valid  = 1'b1;
        decode_o.nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_to_binary.sv
// rtl/seven_segment_to_binary.sv - synchronize, qualify as stable and decode a 7-segment bus
module seven_segment_to_binary
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter bit INVERT        = 1'b0
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  seven_segment_to_binary_if.slave seg_bus
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [7:0]    sync1_q, sync2_q;
  logic [7:0]    w_seg;
  logic [1:0]    state_q, state_d;
  logic [7:0]    cand_q, cand_d;
  logic [7:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    num_q, num_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic          blank_q, blank_d;
  logic          dp_q, dp_d;
  seg_decode_t   dec;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= seg_bus.i_Segments;
      sync2_q <= sync1_q;
    end
  end

  // Polarity is corrected after the synchronizer so both flops stay plain.
  assign w_seg = sync2_q ^ {8{INVERT}};

  seg7_pattern_decode u_decode (
    .pattern_i (cand_q[7:1]),
    .decode_o  (dec)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    blank_d = blank_q;
    dp_d    = dp_q;
    case (state_q)
      ST_IDLE: begin
        if (w_seg != cand_q) begin
          cand_d  = w_seg;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_seg != cand_q) begin
          cand_d = w_seg;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        // Input is not sampled here; a change during this cycle is seen from IDLE.
        state_d = ST_IDLE;
        if (cand_q != last_q) begin
          last_d = cand_q;
          dp_d   = cand_q[0];
          if (dec.blank) begin
            blank_d = 1'b1;
          end else if (dec.valid) begin
            num_d   = dec.nibble;
            dv_d    = 1'b1;
            blank_d = 1'b0;
          end else begin
            err_d   = 1'b1;
            blank_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 1'b1;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
    end
  end

  assign seg_bus.o_Binary_Num = num_q;
  assign seg_bus.o_DV         = dv_q;
  assign seg_bus.o_Err        = err_q;
  assign seg_bus.o_Blank      = blank_q;
  assign seg_bus.o_DP         = dp_q;

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// tb/tb_seven_segment_to_binary.sv - episode-based bench with a run-scanning reference model
module tb_seven_segment_to_binary;

  typedef struct packed {
    logic [3:0] num;
    logic       dv;
    logic       err;
    logic       blank;
    logic       dp;
  } out_t;

  localparam out_t RST_OUT = '{num: 4'h0, dv: 1'b0, err: 1'b0, blank: 1'b1, dp: 1'b0};

  logic [7:0] ref_tab [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seven_segment_to_binary_if if0 ();
  seven_segment_to_binary_if if1 ();

  seven_segment_to_binary #(.STABLE_CYCLES(16), .INVERT(1'b0)) dut0 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .seg_bus (if0)
  );

  seven_segment_to_binary #(.STABLE_CYCLES(4), .INVERT(1'b1)) dut1 (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .seg_bus (if1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int phase  = 0;
  int m_idx  = 0;

  logic [7:0] ep_in[$];
  out_t       mq[$];
  out_t       exp0[$];
  out_t       exp1[$];

  int         dvc0, dvc1, errc0, errc1, first0;
  logic [3:0] dvn0[$];
  logic [3:0] dvn1[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, m_idx);
    end
  endtask

  function automatic int nib_of(input logic [7:0] p);
    for (int i = 0; i < 16; i++)
      if (ref_tab[i][7:1] == p[7:1]) return i;
    return -1;
  endfunction

  // Scan the synchronized sample stream for runs of STABLE+1 equal samples;
  // the cycle after such a run reports, and the sample in that cycle is never seen.
  function automatic void run_model(input int s, input bit inv);
    logic [7:0] w[$];
    out_t       o;
    logic [7:0] cand, last;
    int         len, mm, m, start, n, idx;
    len = ep_in.size();
    mm  = len + 3;
    mq.delete();
    o = RST_OUT;
    mq.push_back(o);
    w.push_back(8'h00);
    for (int k = 1; k <= mm; k++) begin
      idx = (k - 3 < len - 1) ? k - 3 : len - 1;
      w.push_back((k < 3) ? {8{inv}} : ep_in[idx]);
    end
    cand = 8'h00;
    last = 8'h00;
    m    = 1;
    while (m <= mm) begin
      while (m <= mm && w[m] == cand) begin
        mq.push_back(o);
        m++;
      end
      if (m > mm) break;
      cand  = w[m];
      start = m;
      while (m <= mm && m <= start + s) begin
        if (w[m] != cand) begin
          cand  = w[m];
          start = m;
        end
        mq.push_back(o);
        m++;
      end
      if (m > mm) break;
      if (cand != last) begin
        last = cand;
        o.dp = cand[0];
        n    = nib_of(cand);
        if (cand[7:1] == 7'h00) begin
          o.blank = 1'b1;
        end else if (n >= 0) begin
          o.num   = 4'(n);
          o.dv    = 1'b1;
          o.blank = 1'b0;
        end else begin
          o.err   = 1'b1;
          o.blank = 1'b0;
        end
      end
      mq.push_back(o);
      m++;
      o.dv  = 1'b0;
      o.err = 1'b0;
    end
  endfunction

  function automatic int nth0(input int i);
    return (i < dvn0.size()) ? int'(dvn0[i]) : -1;
  endfunction

  function automatic int nth1(input int i);
    return (i < dvn1.size()) ? int'(dvn1[i]) : -1;
  endfunction

  task automatic add(input logic [7:0] v, input int n);
    repeat (n) ep_in.push_back(v);
  endtask

  task automatic drive(input logic [7:0] v);
    if0.i_Segments = v;
    if1.i_Segments = ~v;
  endtask

  task automatic run_episode();
    int len, mm;
    len = ep_in.size();
    mm  = len + 3;
    run_model(16, 1'b0);
    exp0 = mq;
    run_model(4, 1'b1);
    exp1 = mq;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    phase = 1;
    dvc0 = 0; dvc1 = 0; errc0 = 0; errc1 = 0; first0 = -1;
    dvn0.delete();
    dvn1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_idx = 0;
    drive(ep_in[0]);
    phase = 2;
    for (int j = 1; j <= mm; j++) begin
      @(posedge clk);
      #1;
      m_idx = j;
      drive((j < len) ? ep_in[j] : ep_in[len-1]);
    end
    @(negedge clk);
    #1;
    phase = 0;
  endtask

  always @(negedge clk) begin
    if (phase == 1) begin
      chk("reset_out0", {if0.o_Binary_Num, if0.o_DV, if0.o_Err, if0.o_Blank, if0.o_DP}, RST_OUT);
      chk("reset_out1", {if1.o_Binary_Num, if1.o_DV, if1.o_Err, if1.o_Blank, if1.o_DP}, RST_OUT);
    end else if (phase == 2 && m_idx < exp0.size() && m_idx < exp1.size()) begin
      chk("out0", {if0.o_Binary_Num, if0.o_DV, if0.o_Err, if0.o_Blank, if0.o_DP}, exp0[m_idx]);
      chk("out1", {if1.o_Binary_Num, if1.o_DV, if1.o_Err, if1.o_Blank, if1.o_DP}, exp1[m_idx]);
      if (if0.o_DV) begin
        dvc0++;
        dvn0.push_back(if0.o_Binary_Num);
        if (first0 < 0) first0 = m_idx;
      end
      if (if1.o_DV) begin
        dvc1++;
        dvn1.push_back(if1.o_Binary_Num);
      end
      if (if0.o_Err) errc0++;
      if (if1.o_Err) errc1++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int         r;
    drive(8'h00);

    // Pattern first sampled at edge 1, so o_DV lands at edge 1+2+16+1.
    ep_in.delete(); add(8'hDA, 30);
    run_episode();
    chk("e1_model_pin_dv", exp0[20], 8'h28);
    chk("e1_model_pin_pre", exp0[19], 8'h02);
    chk("e1_dv_count", dvc0, 1);
    chk("e1_first_dv_cycle", first0, 20);
    chk("e1_num", nth0(0), 2);
    chk("e1_blank", if0.o_Blank, 0);

    ep_in.delete();
    for (int i = 0; i < 16; i++) add(ref_tab[i], 20);
    run_episode();
    chk("sweep_dv_count", dvc0, 16);
    chk("sweep_err_count", errc0, 0);
    chk("sweep_dv_count_inv", dvc1, 16);
    for (int i = 0; i < 16; i++) chk("sweep_order", nth0(i), i);

    ep_in.delete(); add(8'hF2, 5); add(8'h60, 30);
    run_episode();
    chk("glitch_dv_count", dvc0, 1);
    chk("glitch_num", nth0(0), 1);

    ep_in.delete(); add(8'h60, 20); add(8'h02, 25);
    run_episode();
    chk("illegal_dv_count", dvc0, 1);
    chk("illegal_err_count", errc0, 1);
    chk("illegal_num_held", if0.o_Binary_Num, 1);
    chk("illegal_blank", if0.o_Blank, 0);

    ep_in.delete(); add(8'h9C, 25); add(8'h00, 25);
    run_episode();
    chk("inv_dv_count", dvc1, 1);
    chk("inv_num", nth1(0), 12);
    chk("inv_blank", if1.o_Blank, 1);
    chk("inv_num_held", if1.o_Binary_Num, 12);
    chk("noninv_dv_count", dvc0, 1);

    // Ends mid-settle; the next episode's reset checks the immediate clear.
    ep_in.delete(); add(8'h60, 25); add(8'h9C, 8);
    run_episode();
    chk("midsettle_dv_count", dvc0, 1);

    ep_in.delete(); add(8'h00, 30);
    run_episode();
    chk("post_reset_dv0", dvc0, 0);
    chk("post_reset_dv1", dvc1, 0);
    chk("post_reset_err0", errc0, 0);

    ep_in.delete(); add(8'h60, 20); add(8'h61, 20);
    run_episode();
    chk("dp_dv_count", dvc0, 2);
    chk("dp_second_num", nth0(1), 1);
    chk("dp_level", if0.o_DP, 1);

    for (int e = 0; e < 6; e++) begin
      ep_in.delete();
      v = 8'h00;
      repeat (8) begin
        r = $urandom_range(0, 99);
        if (r < 70)      v = ref_tab[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
        else if (r < 85) v = 8'($urandom_range(0, 1));
        else             v = 8'($urandom_range(0, 255));
        add(v, $urandom_range(1, 24));
      end
      add(v, 25);
      run_episode();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
